// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: holds one decoded instruction, drives ALU operands with MEM/WB forwarding.
// Optional ID_EX_PERF_CNT_EN adds saturating stall/bubble counters.
module id_ex_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int ALUOP_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               id_valid_i,
  output logic               id_ready_o,
  input  logic [XLEN-1:0]    id_pc_i,
  input  logic [RADDR_W-1:0] id_rs1_addr_i,
  input  logic [RADDR_W-1:0] id_rs2_addr_i,
  input  logic [XLEN-1:0]    id_rs1_data_i,
  input  logic [XLEN-1:0]    id_rs2_data_i,
  input  logic [XLEN-1:0]    id_imm_i,
  input  logic               id_use_pc_i,
  input  logic               id_use_imm_i,
  input  logic [ALUOP_W-1:0] id_alu_op_i,
  input  logic [RADDR_W-1:0] id_rd_addr_i,
  input  logic               id_rd_we_i,
  input  logic               mem_we_i,
  input  logic [RADDR_W-1:0] mem_rd_addr_i,
  input  logic [XLEN-1:0]    mem_rd_data_i,
  input  logic               wb_we_i,
  input  logic [RADDR_W-1:0] wb_rd_addr_i,
  input  logic [XLEN-1:0]    wb_rd_data_i,
  output logic               ex_valid_o,
  input  logic               ex_ready_i,
  output logic [XLEN-1:0]    alu_a_o,
  output logic [XLEN-1:0]    alu_b_o,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic [RADDR_W-1:0] ex_rd_addr_o,
  output logic               ex_rd_we_o,
  output logic [XLEN-1:0]    ex_pc_o
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cnt_o,
  output logic [31:0]        bubble_cnt_o
`endif
);

  logic                         valid_q, valid_d;
  logic [XLEN-1:0]              pc_q, pc_d, imm_q, imm_d;
  logic [1:0][RADDR_W-1:0]      rs_addr_q, rs_addr_d;
  logic [1:0][XLEN-1:0]         rs_data_q, rs_data_d;
  logic                         use_pc_q, use_pc_d, use_imm_q, use_imm_d;
  logic [ALUOP_W-1:0]           op_q, op_d;
  logic [RADDR_W-1:0]           rd_q, rd_d;
  logic                         rd_we_q, rd_we_d;

  logic [1:0][RADDR_W-1:0]      id_rs_addr;
  logic [1:0][XLEN-1:0]         id_rs_data, fwd;
  logic                         load, xfer;

  assign id_rs_addr = {id_rs2_addr_i, id_rs1_addr_i};
  assign id_rs_data = {id_rs2_data_i, id_rs1_data_i};

  assign id_ready_o = !valid_q || ex_ready_i;
  assign load       = id_valid_i && id_ready_o;
  assign xfer       = valid_q && ex_ready_i;

  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    imm_d     = imm_q;
    rs_addr_d = rs_addr_q;
    rs_data_d = rs_data_q;
    use_pc_d  = use_pc_q;
    use_imm_d = use_imm_q;
    op_d      = op_q;
    rd_d      = rd_q;
    rd_we_d   = rd_we_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d   = 1'b1;
      pc_d      = id_pc_i;
      imm_d     = id_imm_i;
      rs_addr_d = id_rs_addr;
      use_pc_d  = id_use_pc_i;
      use_imm_d = id_use_imm_i;
      op_d      = id_alu_op_i;
      rd_d      = id_rd_addr_i;
      rd_we_d   = id_rd_we_i;
      // Same-cycle RF write bypasses the stale read data.
      for (int n = 0; n < 2; n++)
        rs_data_d[n] = (wb_we_i && wb_rd_addr_i == id_rs_addr[n] && id_rs_addr[n] != '0)
                       ? wb_rd_data_i : id_rs_data[n];
    end else if (xfer) begin
      valid_d = 1'b0;
    end else if (valid_q && !ex_ready_i) begin
      for (int n = 0; n < 2; n++)
        if (wb_we_i && wb_rd_addr_i == rs_addr_q[n] && rs_addr_q[n] != '0)
          rs_data_d[n] = wb_rd_data_i;
    end
  end

  // MEM is younger than WB, so it wins an address tie; x0 never forwards.
  always_comb begin
    fwd = rs_data_q;
    for (int n = 0; n < 2; n++) begin
      if (mem_we_i && mem_rd_addr_i == rs_addr_q[n] && rs_addr_q[n] != '0)
        fwd[n] = mem_rd_data_i;
      else if (wb_we_i && wb_rd_addr_i == rs_addr_q[n] && rs_addr_q[n] != '0)
        fwd[n] = wb_rd_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      imm_q     <= '0;
      rs_addr_q <= '0;
      rs_data_q <= '0;
      use_pc_q  <= 1'b0;
      use_imm_q <= 1'b0;
      op_q      <= '0;
      rd_q      <= '0;
      rd_we_q   <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      imm_q     <= imm_d;
      rs_addr_q <= rs_addr_d;
      rs_data_q <= rs_data_d;
      use_pc_q  <= use_pc_d;
      use_imm_q <= use_imm_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      rd_we_q   <= rd_we_d;
    end
  end

  assign ex_valid_o   = valid_q;
  assign alu_a_o      = use_pc_q  ? pc_q  : fwd[0];
  assign alu_b_o      = use_imm_q ? imm_q : fwd[1];
  assign alu_op_o     = op_q;
  assign ex_rd_addr_o = rd_q;
  assign ex_rd_we_o   = rd_we_q && valid_q;
  assign ex_pc_o      = pc_q;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (valid_q && !ex_ready_i && stall_cnt_q != '1) stall_cnt_d  = stall_cnt_q + 32'd1;
    if (!valid_q && bubble_cnt_q != '1)              bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed test-plan cases, then random traffic
// checked against an architectural register-file model.
module tb_id_ex_stage;
  logic        clk, rst, flush, id_valid, id_ready;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_alu_op, id_rd_addr;
  logic        id_use_pc, id_use_imm, id_rd_we;
  logic        mem_we, wb_we;
  logic [4:0]  mem_rd_addr, wb_rd_addr;
  logic [31:0] mem_rd_data, wb_rd_data;
  logic        ex_valid, ex_ready, ex_rd_we;
  logic [31:0] alu_a, alu_b, ex_pc;
  logic [4:0]  alu_op, ex_rd_addr;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt, bubble_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;

  id_ex_stage dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .id_valid_i(id_valid), .id_ready_o(id_ready), .id_pc_i(id_pc),
    .id_rs1_addr_i(id_rs1_addr), .id_rs2_addr_i(id_rs2_addr),
    .id_rs1_data_i(id_rs1_data), .id_rs2_data_i(id_rs2_data),
    .id_imm_i(id_imm), .id_use_pc_i(id_use_pc), .id_use_imm_i(id_use_imm),
    .id_alu_op_i(id_alu_op), .id_rd_addr_i(id_rd_addr), .id_rd_we_i(id_rd_we),
    .mem_we_i(mem_we), .mem_rd_addr_i(mem_rd_addr), .mem_rd_data_i(mem_rd_data),
    .wb_we_i(wb_we), .wb_rd_addr_i(wb_rd_addr), .wb_rd_data_i(wb_rd_data),
    .ex_valid_o(ex_valid), .ex_ready_i(ex_ready),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
    .ex_rd_addr_o(ex_rd_addr), .ex_rd_we_o(ex_rd_we), .ex_pc_o(ex_pc)
`ifdef ID_EX_PERF_CNT_EN
    , .stall_cnt_o(stall_cnt), .bubble_cnt_o(bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; id_valid = 0; id_pc = 0; id_rs1_addr = 0; id_rs2_addr = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_use_pc = 0; id_use_imm = 0;
    id_alu_op = 0; id_rd_addr = 0; id_rd_we = 0; mem_we = 0; mem_rd_addr = 0;
    mem_rd_data = 0; wb_we = 0; wb_rd_addr = 0; wb_rd_data = 0; ex_ready = 1;
  endtask

  task automatic present(input logic [4:0] a1, input logic [31:0] d1,
                         input logic [4:0] a2, input logic [31:0] d2,
                         input logic [4:0] op, input logic [4:0] rd);
    id_valid = 1; id_rs1_addr = a1; id_rs1_data = d1; id_rs2_addr = a2; id_rs2_data = d2;
    id_alu_op = op; id_rd_addr = rd; id_rd_we = 1; id_use_pc = 0; id_use_imm = 0;
  endtask

  // Reference model: an architectural register file plus the one held instruction.
  logic [31:0] regs [32];
  logic        m_valid, m_upc, m_uimm, m_we;
  logic [31:0] m_pc, m_imm;
  logic [4:0]  m_a1, m_a2, m_op, m_rd;
  logic [31:0] m_stall, m_bubble;

  // Newest value of a register as seen by an instruction about to execute.
  function automatic logic [31:0] arch(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (mem_we && mem_rd_addr == a) return mem_rd_data;
    if (wb_we && wb_rd_addr == a) return wb_rd_data;
    return regs[a];
  endfunction

  task automatic model_step();
    logic accept;
    accept = id_valid && (!m_valid || ex_ready);
    if (rst) begin
      m_valid = 0; m_stall = 0; m_bubble = 0;
    end else begin
      if (m_valid && !ex_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (!m_valid && m_bubble != 32'hFFFF_FFFF) m_bubble++;
      if (flush) m_valid = 0;
      else if (accept) begin
        m_valid = 1; m_pc = id_pc; m_imm = id_imm; m_a1 = id_rs1_addr; m_a2 = id_rs2_addr;
        m_upc = id_use_pc; m_uimm = id_use_imm; m_op = id_alu_op; m_rd = id_rd_addr; m_we = id_rd_we;
      end else if (m_valid && ex_ready) m_valid = 0;
    end
    if (wb_we && wb_rd_addr != 0) regs[wb_rd_addr] = wb_rd_data;
  endtask

  initial begin
    idle();
    rst = 1;
    tick(); tick();
`ifdef ID_EX_PERF_CNT_EN
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_bubble_cnt", bubble_cnt, 0);
`endif
    rst = 0;
    #1;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_id_ready", id_ready, 1);
    chk("rst_outs", {alu_a, alu_b, alu_op, ex_rd_addr, ex_rd_we, ex_pc}, 0);

    // ADD 5 + 7
    present(5'd1, 32'd5, 5'd2, 32'd7, 5'h01, 5'd9);
    tick();
    idle();
    #1;
    chk("add_valid", ex_valid, 1);
    chk("add_a", alu_a, 5);
    chk("add_b", alu_b, 7);
    chk("add_op", alu_op, 5'h01);
    chk("add_rd", {ex_rd_addr, ex_rd_we}, {5'd9, 1'b1});

    // Forwarding priority and x0 guard on a held instruction
    present(5'd3, 32'd1, 5'd0, 32'd0, 5'h02, 5'd10);
    tick();
    idle();
    ex_ready = 0;
    mem_we = 1; mem_rd_addr = 3; mem_rd_data = 32'hAA;
    wb_we = 1; wb_rd_addr = 3; wb_rd_data = 32'hBB;
    #1 chk("fwd_mem_wins", alu_a, 32'hAA);
    mem_we = 0;
    #1 chk("fwd_wb", alu_a, 32'hBB);
    wb_rd_addr = 0; wb_rd_data = 32'h55; mem_we = 1; mem_rd_addr = 0; mem_rd_data = 32'h66;
    #1 chk("x0_guard", alu_b, 0);

    // Stall refresh of rs1=x4
    idle();
    present(5'd4, 32'h11, 5'd6, 32'h22, 5'h03, 5'd11);
    tick();
    idle();
    ex_ready = 0;
    wb_we = 1; wb_rd_addr = 4; wb_rd_data = 32'h1234;
    #1 chk("stall_c1_ready", id_ready, 0);
    tick();
    wb_we = 0; wb_rd_data = 0;
    #1 chk("stall_c2_a", alu_a, 32'h1234);
    chk("stall_c2_ready", id_ready, 0);
    tick();
    chk("stall_c3_a", alu_a, 32'h1234);
    chk("stall_c3_b", alu_b, 32'h22);
    chk("stall_c3_ready", id_ready, 0);
    chk("stall_c3_valid", ex_valid, 1);

    // Flush concurrent with a load
    ex_ready = 1;
    present(5'd7, 32'h9, 5'd8, 32'h9, 5'h04, 5'd12);
    flush = 1;
    #1 chk("flush_id_ready", id_ready, 1);
    tick();
    idle();
    #1;
    chk("flush_valid", ex_valid, 0);
    chk("flush_rd_we", ex_rd_we, 0);

    // Immediate and PC selection
    present(5'd1, 32'd3, 5'd2, 32'd4, 5'h05, 5'd13);
    id_use_imm = 1; id_imm = 32'hFFFF_FFF0; id_use_pc = 1; id_pc = 32'h100;
    tick();
    idle();
    #1;
    chk("imm_b", alu_b, 32'hFFFF_FFF0);
    chk("pc_a", alu_a, 32'h100);
    chk("pc_o", ex_pc, 32'h100);

`ifdef ID_EX_PERF_CNT_EN
    rst = 1;
    tick();
    rst = 0;
    chk("perf_clr0", {stall_cnt, bubble_cnt}, 0);
    tick();
    present(5'd1, 32'd1, 5'd2, 32'd2, 5'h01, 5'd1);
    tick();
    idle();
    ex_ready = 0;
    repeat (4) tick();
    chk("perf_stall", stall_cnt, 4);
    chk("perf_bubble", bubble_cnt, 2);
    rst = 1;
    tick();
    rst = 0;
    chk("perf_clr1", {stall_cnt, bubble_cnt}, 0);
`endif

    // Random traffic against the architectural model
    idle();
    rst = 1;
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : $urandom;
    model_step();
    tick();
    rst = 0;
    m_stall = 0; m_bubble = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst         = ($urandom_range(0, 99) < 2);
      flush       = ($urandom_range(0, 99) < 8);
      id_valid    = ($urandom_range(0, 99) < 70);
      ex_ready    = ($urandom_range(0, 99) < 65);
      id_pc       = $urandom;
      id_imm      = $urandom;
      id_use_pc   = ($urandom_range(0, 3) == 0);
      id_use_imm  = ($urandom_range(0, 3) == 0);
      id_alu_op   = 5'($urandom_range(0, 31));
      id_rd_addr  = 5'($urandom_range(0, 31));
      id_rd_we    = 1'($urandom_range(0, 1));
      id_rs1_addr = 5'($urandom_range(0, 7));
      id_rs2_addr = 5'($urandom_range(0, 7));
      id_rs1_data = regs[id_rs1_addr];
      id_rs2_data = regs[id_rs2_addr];
      mem_we      = 1'($urandom_range(0, 1));
      mem_rd_addr = 5'($urandom_range(0, 7));
      mem_rd_data = $urandom;
      wb_we       = 1'($urandom_range(0, 1));
      wb_rd_addr  = 5'($urandom_range(0, 7));
      wb_rd_data  = $urandom;
      #1;
      chk("r_id_ready", id_ready, !m_valid || ex_ready);
      chk("r_ex_valid", ex_valid, m_valid);
      chk("r_rd_we", ex_rd_we, m_valid && m_we);
      if (m_valid) begin
        chk("r_alu_a", alu_a, m_upc ? m_pc : arch(m_a1));
        chk("r_alu_b", alu_b, m_uimm ? m_imm : arch(m_a2));
        chk("r_alu_op", alu_op, m_op);
        chk("r_rd_addr", ex_rd_addr, m_rd);
        chk("r_pc", ex_pc, m_pc);
      end
`ifdef ID_EX_PERF_CNT_EN
      chk("r_stall_cnt", stall_cnt, m_stall);
      chk("r_bubble_cnt", bubble_cnt, m_bubble);
`endif
      model_step();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between instruction decode and the ALU; holds one decoded instruction.
- Drives the ALU operand inputs (A, B) and the 5-bit ALU opcode.
- Resolves operand hazards by forwarding from the MEM and WB stages.
- Refreshes a held operand when WB retires a matching write during a stall.

Parameters:
- XLEN, 32, data and operand width
- RADDR_W, 5, register address width
- ALUOP_W, 5, ALU opcode width, matching the ALU's ALUOp encoding

Ports:
- clk_i  in  1  clock; all state changes on the rising edge
- rst_i  in  1  synchronous reset, active-high
- flush_i  in  1  kill the held instruction and any instruction loading this cycle
- id_valid_i  in  1  decode presents an instruction
- id_ready_o  out  1  stage can accept an instruction
- id_pc_i  in  XLEN  instruction PC
- id_rs1_addr_i, id_rs2_addr_i  in  RADDR_W  source register addresses
- id_rs1_data_i, id_rs2_data_i  in  XLEN  register-file read data
- id_imm_i  in  XLEN  sign-extended immediate
- id_use_pc_i  in  1  operand A = PC (AUIPC/JAL)
- id_use_imm_i  in  1  operand B = immediate
- id_alu_op_i  in  ALUOP_W  ALU operation
- id_rd_addr_i  in  RADDR_W  destination register
- id_rd_we_i  in  1  instruction writes rd
- mem_we_i  in  1  MEM stage will write a register
- mem_rd_addr_i  in  RADDR_W  MEM destination
- mem_rd_data_i  in  XLEN  MEM result
- wb_we_i  in  1  WB writes the register file this cycle
- wb_rd_addr_i  in  RADDR_W  WB destination
- wb_rd_data_i  in  XLEN  WB data
- ex_valid_o  out  1  ALU inputs are valid
- ex_ready_i  in  1  downstream consumes the instruction
- alu_a_o, alu_b_o  out  XLEN  ALU operands
- alu_op_o  out  ALUOP_W  ALU opcode
- ex_rd_addr_o  out  RADDR_W  destination register
- ex_rd_we_o  out  1  destination write enable (0 when not valid)
- ex_pc_o  out  XLEN  held PC

Behaviour:
Handshake:
- Single entry. id_ready_o = !ex_valid_o | ex_ready_i, combinational and independent of flush_i.
- load = id_valid_i & id_ready_o. Transfer out = ex_valid_o & ex_ready_i.

Registered state:
- valid_q, pc_q, rs1/rs2 addr_q, rs1/rs2 data_q, imm_q, use_pc_q, use_imm_q, op_q, rd_q, rd_we_q.

Reset:
- All state registers clear to 0.
- Resulting outputs: ex_valid_o=0, alu_a_o=0, alu_b_o=0, alu_op_o=0, ex_rd_addr_o=0, ex_rd_we_o=0, ex_pc_o=0, id_ready_o=1.

Per-edge update priority (highest first):
1. rst_i: reset as above.
2. flush_i: valid_q <= 0; other fields don't-care.
3. load: capture every id_* field and set valid_q <= 1. rsN_data_q takes wb_rd_data_i when wb_we_i & wb_rd_addr_i==id_rsN_addr_i & addr!=0, else id_rsN_data_i. This covers register-file write/read in the same cycle.
4. Transfer without load: valid_q <= 0.
5. Hold (valid_q & !ex_ready_i): for each source N, if wb_we_i & wb_rd_addr_i==rsN_addr_q & rsN_addr_q!=0 then rsN_data_q <= wb_rd_data_i.

Forwarding (combinational, applied to the held operand):
- fwdN = mem_rd_data_i if mem_we_i & mem_rd_addr_i==rsN_addr_q & rsN_addr_q!=0.
- Otherwise wb_rd_data_i if wb_we_i & wb_rd_addr_i==rsN_addr_q & rsN_addr_q!=0.
- Otherwise rsN_data_q. MEM beats WB on an address tie; x0 is never forwarded.

Outputs:
- alu_a_o = use_pc_q ? pc_q : fwd1.
- alu_b_o = use_imm_q ? imm_q : fwd2.
- alu_op_o = op_q.
- ex_rd_we_o = rd_we_q & valid_q.
- Zero latency from the register to the outputs; one cycle from ID acceptance to ex_valid_o.

Boundary cases:
- Back-to-back throughput is 1 instruction per cycle when ex_ready_i=1.
- A flush in the same cycle as a load drops the incoming instruction, and id_ready_o still reads 1.
- A stall of any length preserves all fields except the refreshed operands.
- Reset mid-stall discards the held instruction.

Optional Feature:
- Macro ID_EX_PERF_CNT_EN.
- When defined: adds output stall_cnt_o (32 bits) and output bubble_cnt_o (32 bits).
  - stall_cnt_o increments each cycle with ex_valid_o & !ex_ready_i.
  - bubble_cnt_o increments each cycle with !ex_valid_o.
  - Both clear on rst_i, saturate at 0xFFFFFFFF and are unaffected by flush_i.
- When undefined: neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Reset, then deassert: ex_valid_o=0, id_ready_o=1 and all outputs 0. Load ADD with rs1 data 5 and rs2 data 7 (ex_ready_i=1) → next cycle ex_valid_o=1, alu_a_o=5, alu_b_o=7, alu_op_o=ADD.
- Forwarding priority: held rs1=x3 with stale data 1; mem_we_i=1, mem_rd_addr_i=3, mem_rd_data_i=0xAA; wb_we_i=1, wb_rd_addr_i=3, wb_rd_data_i=0xBB → alu_a_o=0xAA. Drop mem_we_i → 0xBB.
- x0 guard: rs2=x0 with wb_we_i=1, wb_rd_addr_i=0, wb_rd_data_i=0x55 → alu_b_o=0.
- Stall refresh: hold rs1=x4 with ex_ready_i=0 for 3 cycles; WB writes x4=0x1234 in cycle 1 only → alu_a_o=0x1234 in cycles 2–3. id_ready_o=0 throughout the stall.
- Flush: held valid instruction, plus id_valid_i=1 and flush_i=1 in the same cycle → next cycle ex_valid_o=0 and ex_rd_we_o=0. Immediate selection: use_imm=1, imm=0xFFFFFFF0 → alu_b_o=0xFFFFFFF0. use_pc=1, pc=0x100 → alu_a_o=0x100.
- With ID_EX_PERF_CNT_EN defined: 4 stall cycles and 2 empty cycles → stall_cnt_o=4 and bubble_cnt_o=2, then rst_i clears both to 0.
